spi_sub_param: RTL and testbench
================================

Name: spi_sub_param

Overview:
- Parametrised, system-clocked SPI subordinate; next generation of the lab SPI slave.
- sclk, cs_n and mosi are treated as asynchronous inputs, synchronised, and edge-detected on clk. No logic runs on sclk itself.
- Supports configurable word width, all four CPOL/CPHA modes, bit order, back-to-back words within one cs_n assertion, and a one-word TX holding buffer.
- Sits between an external SPI controller and local user logic.

Parameters:
- DATA_W, 8: bits per word (2..32).
- CPOL, 0: idle level of sclk.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB shifted first.
- SYNC_STAGES, 2: synchroniser depth for sclk/cs_n/mosi (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous.
- cs_n  in  1  chip select, active-low, asynchronous.
- mosi  in  1  controller-out data, asynchronous.
- miso  out  1  subordinate-out data.
- miso_oe  out  1  output enable for the miso pad; high while cs_n is low (synchronised).
- tx_data  in  DATA_W  word to transmit.
- tx_load  in  1  write tx_data into the holding buffer; accepted only when tx_ready=1.
- tx_ready  out  1  holding buffer empty.
- rx_data  out  DATA_W  last complete received word; held until the next word completes.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- tx_underrun  out  1  one-clk pulse: word started with an empty holding buffer.
- busy  out  1  cs_n asserted (synchronised).

Behaviour:
- Reset values, all synchronous on clk: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0. Shift registers, bit counter and holding buffer are cleared.
- Reset asserted mid-frame aborts the frame. After reset releases, the block waits for a fresh cs_n falling edge.
- Synchronisation: each async input passes through SYNC_STAGES flops. Edges are detected on the synchronised sclk.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Clock ratio: clk must be >= 8x sclk. Slower clk is unsupported and is not checked.
- State machine:
  - IDLE -> LOAD on synchronised cs_n falling edge.
  - LOAD (1 clk): copy the holding buffer into tx_shift and set tx_ready=1. If the buffer was empty, load all zeros and pulse tx_underrun. If CPHA=0, drive the first bit on miso this cycle. Go to XFER.
  - XFER:
    - Sample edge: shift mosi into rx_shift (direction per MSB_FIRST) and increment bit_cnt.
    - Shift edge: present the next tx bit on miso. For CPHA=1 the first shift edge presents bit 0 of the word.
    - When bit_cnt reaches DATA_W on a sample edge: next clk, rx_data <= rx_shift, rx_valid=1 for one clk, bit_cnt wraps to 0, go to LOAD for the next word.
  - Any state -> IDLE on synchronised cs_n rising edge. The partial word is discarded: no rx_valid, bit_cnt=0, miso_oe=0, miso=0. The holding buffer is kept.
- Holding buffer:
  - tx_load with tx_ready=1 stores tx_data and clears tx_ready next clk.
  - tx_load with tx_ready=0 is ignored.
  - tx_load in the same clk as LOAD with an empty buffer: tx_data goes directly to tx_shift, no underrun, tx_ready stays 1.
- bit_cnt width is clog2(DATA_W+1). The counter never exceeds DATA_W.
- rx_data is never overwritten by a partial word. There is no RX back-pressure: user logic must consume rx_data within one word time.
- sclk edges while cs_n is high are ignored.
- cs_n falling and sclk edge in the same synchronised cycle: LOAD takes priority and the sclk edge is ignored. The controller must respect setup time.

Decomposition:
- Package spi_pkg:
  - mode encoding constants SPI_MODE0..3 (CPOL, CPHA pairs);
  - state typedef IDLE/LOAD/XFER;
  - function for bit_cnt width.
- Sub-module spi_edge_sync: parametrised SYNC_STAGES synchroniser plus rise/fall pulse generation. One instance each for sclk and cs_n; mosi uses a synchroniser only.

Test Plan:
- Mode 0, DATA_W=8, MSB first: preload 0xA5, controller sends 0x3C -> miso shows bits 1,0,1,0,0,1,0,1; rx_data=0x3C with a single rx_valid pulse; tx_ready rises at LOAD.
- Modes 1, 2, 3, each with tx=0x81, rx=0x7E -> exact bit patterns on miso and correct rx_data; in CPHA=1, miso is not driven before the first leading edge.
- Three back-to-back words (0x11, 0x22, 0x33) in one cs_n assertion; the second buffer is loaded during word 1 and the third is not loaded -> miso 0x11, 0x22, 0x00; one tx_underrun pulse; three rx_valid pulses.
- cs_n deasserted after 5 bits -> no rx_valid; rx_data retains the previous value; next frame with 0x5A received correctly.
- reset asserted for 1 clk after 3 bits -> all outputs at reset values; next full frame with 0xC3 works.
- DATA_W=12, MSB_FIRST=0, mode 0: tx=0xABC, rx=0x123 -> LSB-first ordering on miso; rx_data=0x123.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI subordinate: mode encodings, FSM states and counter sizing.
package spi_pkg;

    // Each mode is the pair {CPOL, CPHA}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } state_t;

    // The bit counter has to hold values from 0 up to data_w.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous pin, plus one-clk rise/fall pulses.
// Pulses appear SYNC_STAGES+1 clks after the pin toggles; there is no flow control.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Deliberately not reset: the flops always mirror the pin, so releasing
    // reset while cs_n is already low cannot fake a falling edge.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        last_q <= sync_q[SYNC_STAGES-1];
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & last_q;

endmodule

// File: rtl/spi_sub_param.sv
// System-clocked SPI subordinate that supports all modes, a configurable width and a one-word TX holding buffer.
// rx_valid arrives 1 clk after the last sample edge is detected; there is no RX back-pressure.
module spi_sub_param
    import spi_pkg::*;
#(
    parameter int   DATA_W      = 8,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter logic MSB_FIRST   = 1'b1,
    parameter int   SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);
    localparam int               CNT_W       = bit_cnt_w(DATA_W);
    localparam logic [1:0]       MODE        = {CPOL, CPHA};
    localparam logic             SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
    localparam logic             IDLE_HIGH   = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(DATA_W);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk) begin
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign lead_edge   = IDLE_HIGH ? sclk_fall : sclk_rise;
    assign trail_edge  = IDLE_HIGH ? sclk_rise : sclk_fall;
    assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
    assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift, rx_shift, hold_dat;
    logic              hold_full;
    logic [DATA_W-1:0] load_word, tx_src, tx_rest;
    logic              load_empty, tx_bit, take;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = LOAD;
            LOAD:    state_nxt = XFER;
            XFER:    if (bit_cnt == LAST) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
        if (cs_rise) state_nxt = IDLE;
    end

    // A tx_load landing in LOAD with an empty buffer bypasses it straight into the shifter.
    always_comb begin
        load_word  = '0;
        load_empty = 1'b0;
        if (hold_full)    load_word = hold_dat;
        else if (tx_load) load_word = tx_data;
        else              load_empty = 1'b1;
        tx_src  = (state == LOAD) ? load_word : tx_shift;
        tx_bit  = MSB_FIRST ? tx_src[DATA_W-1] : tx_src[0];
        tx_rest = MSB_FIRST ? (tx_src << 1) : (tx_src >> 1);
        take    = (state == LOAD) && !cs_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold_dat    <= '0;
            hold_full   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (tx_load && !hold_full && !take) begin
                hold_dat  <= tx_data;
                hold_full <= 1'b1;
            end
            if (cs_rise) begin
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        hold_full   <= 1'b0;
                        tx_underrun <= load_empty;
                        bit_cnt     <= '0;
                        rx_shift    <= '0;
                        if (SAMPLE_LEAD) begin
                            miso     <= tx_bit;
                            tx_shift <= tx_rest;
                        end else begin
                            tx_shift <= load_word;
                        end
                    end
                    XFER: begin
                        if (bit_cnt == LAST) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                        end else if (sample_edge) begin
                            rx_shift <= MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s}
                                                  : {mosi_s, rx_shift[DATA_W-1:1]};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end else if (shift_edge && (!SAMPLE_LEAD || bit_cnt != '0)) begin
                            // In CPHA=0 bit 0 went out in LOAD, so the stray trailing
                            // edge of the previous word must not advance the shifter.
                            miso     <= tx_bit;
                            tx_shift <= tx_rest;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy     = (state != IDLE);
    assign miso_oe  = busy;
    assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_sub_param.sv
// Drives four DATA_W=8 instances (modes 0..3) and one 12-bit LSB-first instance as an SPI controller.
`timescale 1ns/1ps
module tb_spi_sub_param;
    localparam int H  = 8;
    localparam int NU = 5;

    logic clk = 1'b0;
    logic reset;
    logic [NU-1:0] sclk, cs_n, mosi, tx_load;
    logic miso_o [NU];
    logic oe_o   [NU];
    logic rdy_o  [NU];
    logic rxv_o  [NU];
    logic und_o  [NU];
    logic busy_o [NU];
    logic [7:0]  tx8 [4];
    logic [7:0]  rx8 [4];
    logic [11:0] tx12, rx12;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_sub_param #(
            .DATA_W(8), .CPOL(((g >> 1) & 1) == 1), .CPHA((g & 1) == 1),
            .MSB_FIRST(1'b1), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .reset(reset), .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi[g]),
            .miso(miso_o[g]), .miso_oe(oe_o[g]), .tx_data(tx8[g]), .tx_load(tx_load[g]),
            .tx_ready(rdy_o[g]), .rx_data(rx8[g]), .rx_valid(rxv_o[g]),
            .tx_underrun(und_o[g]), .busy(busy_o[g])
        );
    end

    spi_sub_param #(
        .DATA_W(12), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(2)
    ) u_dut12 (
        .clk(clk), .reset(reset), .sclk(sclk[4]), .cs_n(cs_n[4]), .mosi(mosi[4]),
        .miso(miso_o[4]), .miso_oe(oe_o[4]), .tx_data(tx12), .tx_load(tx_load[4]),
        .tx_ready(rdy_o[4]), .rx_data(rx12), .rx_valid(rxv_o[4]),
        .tx_underrun(und_o[4]), .busy(busy_o[4])
    );

    int errors = 0;
    int checks = 0;
    int vcnt [NU] = '{default: 0};
    int ucnt [NU] = '{default: 0};
    logic [31:0] exp_q [$];

    function automatic logic unit_cpol(input int u); return (u == 2) || (u == 3); endfunction
    function automatic logic unit_cpha(input int u); return (u == 1) || (u == 3); endfunction
    function automatic int   unit_w(input int u);    return (u == 4) ? 12 : 8;    endfunction
    function automatic logic unit_msb(input int u);  return (u != 4);             endfunction
    function automatic logic [31:0] rx_of(input int u);
        return (u == 4) ? {20'b0, rx12} : {24'b0, rx8[u]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rx_valid pops the oldest expected word.
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (rxv_o[u]) begin
                vcnt[u]++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected_u%0d: got 0x%0h, want no rx_valid", u, rx_of(u));
                end else begin
                    chk($sformatf("rx_word_u%0d", u), rx_of(u), exp_q.pop_front());
                end
            end
            if (und_o[u]) ucnt[u]++;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input int u, input logic [31:0] d);
        if (u == 4) tx12 = d[11:0];
        else        tx8[u] = d[7:0];
        tx_load[u] = 1'b1;
        clks(1);
        tx_load[u] = 1'b0;
    endtask

    task automatic xfer_word(input int u, input logic [31:0] mo, input int nbits,
                             input int load_bit, input logic [31:0] load_dat,
                             output logic [31:0] mi);
        logic cp;
        cp = unit_cpol(u);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            int pos;
            pos = unit_msb(u) ? unit_w(u) - 1 - i : i;
            if (!unit_cpha(u)) begin
                mosi[u] = mo[pos];
                clks(H);
                mi[pos] = miso_o[u];
                sclk[u] = ~cp;
                clks(H);
                sclk[u] = cp;
            end else begin
                clks(H);
                sclk[u] = ~cp;
                mosi[u] = mo[pos];
                clks(H);
                mi[pos] = miso_o[u];
                sclk[u] = cp;
            end
            if (i == load_bit) pulse_load(u, load_dat);
        end
    endtask

    task automatic start_frame(input int u);
        cs_n[u] = 1'b0;
        clks(2 * H);
    endtask

    task automatic end_frame(input int u);
        clks(2 * H);
        cs_n[u] = 1'b1;
        clks(2 * H);
    endtask

    typedef struct {
        int          unit;
        logic [31:0] tx;
        logic [31:0] mo;
        logic [31:0] exp_miso;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [31:0] m1, m2, m3;
        int v0, u0;

        vecs[0] = '{0, 32'h0A5, 32'h03C, 32'h0A5, 32'h03C};
        vecs[1] = '{1, 32'h081, 32'h07E, 32'h081, 32'h07E};
        vecs[2] = '{2, 32'h081, 32'h07E, 32'h081, 32'h07E};
        vecs[3] = '{3, 32'h081, 32'h07E, 32'h081, 32'h07E};
        vecs[4] = '{4, 32'hABC, 32'h123, 32'hABC, 32'h123};

        reset   = 1'b1;
        sclk    = 5'b01100;
        cs_n    = '1;
        mosi    = '0;
        tx_load = '0;
        tx8     = '{default: 8'h00};
        tx12    = '0;
        clks(5);
        reset = 1'b0;
        clks(1);

        for (int u = 0; u < NU; u++) begin
            chk($sformatf("rst_busy_u%0d", u), busy_o[u], 0);
            chk($sformatf("rst_oe_u%0d", u), oe_o[u], 0);
            chk($sformatf("rst_ready_u%0d", u), rdy_o[u], 1);
            chk($sformatf("rst_miso_u%0d", u), miso_o[u], 0);
            chk($sformatf("rst_rx_u%0d", u), rx_of(u), 0);
        end

        for (int k = 0; k < 5; k++) begin
            int u;
            logic [31:0] mi;
            u = vecs[k].unit;
            pulse_load(u, vecs[k].tx);
            chk($sformatf("v%0d_ready_low", k), rdy_o[u], 0);
            v0 = vcnt[u];
            u0 = ucnt[u];
            exp_q.push_back(vecs[k].exp_rx);
            start_frame(u);
            chk($sformatf("v%0d_busy", k), busy_o[u], 1);
            chk($sformatf("v%0d_oe", k), oe_o[u], 1);
            chk($sformatf("v%0d_ready_at_load", k), rdy_o[u], 1);
            chk($sformatf("v%0d_no_underrun", k), ucnt[u] - u0, 0);
            if (unit_cpha(u)) chk($sformatf("v%0d_miso_before_lead", k), miso_o[u], 0);
            xfer_word(u, vecs[k].mo, unit_w(u), -1, 0, mi);
            end_frame(u);
            chk($sformatf("v%0d_miso_word", k), mi, vecs[k].exp_miso);
            chk($sformatf("v%0d_rx_data", k), rx_of(u), vecs[k].exp_rx);
            chk($sformatf("v%0d_valid_pulses", k), vcnt[u] - v0, 1);
            chk($sformatf("v%0d_queue_drained", k), exp_q.size(), 0);
            chk($sformatf("v%0d_idle_after", k), busy_o[u], 0);
        end

        // Three words in one frame, the third with an empty buffer.
        pulse_load(0, 32'h11);
        v0 = vcnt[0];
        u0 = ucnt[0];
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h33);
        start_frame(0);
        xfer_word(0, 32'h11, 8, 3, 32'h22, m1);
        xfer_word(0, 32'h22, 8, -1, 0, m2);
        chk("b2b_underrun_word3", ucnt[0] - u0, 1);
        xfer_word(0, 32'h33, 8, -1, 0, m3);
        end_frame(0);
        chk("b2b_miso_w1", m1, 32'h11);
        chk("b2b_miso_w2", m2, 32'h22);
        chk("b2b_miso_w3", m3, 32'h00);
        chk("b2b_valid_pulses", vcnt[0] - v0, 3);
        chk("b2b_queue_drained", exp_q.size(), 0);

        // Frame aborted after 5 bits, then a clean frame.
        v0 = vcnt[0];
        start_frame(0);
        xfer_word(0, 32'hFF, 5, -1, 0, m1);
        end_frame(0);
        chk("abort_no_valid", vcnt[0] - v0, 0);
        chk("abort_rx_kept", rx_of(0), 32'h33);
        chk("abort_idle", busy_o[0], 0);
        pulse_load(0, 32'h96);
        exp_q.push_back(32'h5A);
        start_frame(0);
        xfer_word(0, 32'h5A, 8, -1, 0, m1);
        end_frame(0);
        chk("post_abort_miso", m1, 32'h96);
        chk("post_abort_rx", rx_of(0), 32'h5A);
        chk("post_abort_queue", exp_q.size(), 0);

        // One-clk reset after 3 bits, then a full frame.
        pulse_load(0, 32'hFF);
        start_frame(0);
        xfer_word(0, 32'hAA, 3, -1, 0, m1);
        chk("pre_reset_miso", miso_o[0], 1);
        reset = 1'b1;
        clks(1);
        reset = 1'b0;
        chk("mid_rst_miso", miso_o[0], 0);
        chk("mid_rst_oe", oe_o[0], 0);
        chk("mid_rst_ready", rdy_o[0], 1);
        chk("mid_rst_rx", rx_of(0), 0);
        chk("mid_rst_valid", rxv_o[0], 0);
        chk("mid_rst_underrun", und_o[0], 0);
        chk("mid_rst_busy", busy_o[0], 0);
        clks(2 * H);
        chk("post_rst_wait_idle", busy_o[0], 0);
        cs_n[0] = 1'b1;
        clks(2 * H);
        pulse_load(0, 32'h3C);
        exp_q.push_back(32'hC3);
        start_frame(0);
        xfer_word(0, 32'hC3, 8, -1, 0, m1);
        end_frame(0);
        chk("post_rst_miso", m1, 32'h3C);
        chk("post_rst_rx", rx_of(0), 32'hC3);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
